// File: rtl/alu_share_arbiter.sv
// Shares one WIDTH-bit ALU between two valid/ready requesters; result is registered one cycle after accept.
// Optional macro ALU_ARB_FIXED_PRIO_EN: req0 always wins conflicts (default: round-robin).
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             slot_free;
  logic             grant_any;
  logic             grant_id;
  logic [2:0]       sel_ctrl;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] alu_res;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif

  function automatic logic [WIDTH-1:0] alu_op(input logic [2:0] ctrl,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (ctrl)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b101:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign rsp_valid = (state == FULL);
  assign slot_free = (state == EMPTY) || rsp_ready;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (!rst && slot_free) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant_id  = 1'b0;
`else
        grant_id  = ~last_grant;
`endif
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any & ~grant_id;
  assign req1_ready = grant_any & grant_id;

  assign sel_ctrl = grant_id ? req1_ctrl : req0_ctrl;
  assign sel_a    = grant_id ? req1_a    : req0_a;
  assign sel_b    = grant_id ? req1_b    : req0_b;
  assign alu_res  = alu_op(sel_ctrl, sel_a, sel_b);

  // A drain in the same cycle as an accept keeps the slot FULL.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (grant_any) state_nxt = FULL;
      FULL:    if (rsp_ready && !grant_any) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        rsp_id   <= grant_id;
        rsp_data <= alu_res;
        rsp_zero <= (alu_res == '0);
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant <= grant_id;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed literal checks plus randomized traffic against a queue-free reference model.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_ctrl = '0, req1_ctrl = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero;
  logic [W-1:0] rsp_data;

  int n_chk = 0;
  int n_err = 0;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    if (c == 3'd0) return a + b;
    if (c == 3'd1) return a - b;
    if (c == 3'd2) return a & b;
    if (c == 3'd3) return a | b;
    if (c == 3'd5) return (int'(a) < int'(b)) ? 1 : 0;
    return 0;
  endfunction

  // Reference model: contents of the output slot and the requester that won last.
  logic         m_valid = 1'b0, m_id = 1'b0, m_zero = 1'b0, m_last = 1'b1;
  logic [W-1:0] m_data = '0;
  logic         p0_stall = 1'b0, p1_stall = 1'b0;
  logic [2:0]   p0_c, p1_c;
  logic [W-1:0] p0_a, p0_b, p1_a, p1_b;

  always @(negedge clk) begin
    bit       e0, e1, g, any;
    any = 1'b0; g = 1'b0;
    if (!rst && (!m_valid || rsp_ready)) begin
      if (req0_valid && req1_valid) begin any = 1'b1; g = FIXED ? 1'b0 : !m_last; end
      else if (req0_valid) begin any = 1'b1; g = 1'b0; end
      else if (req1_valid) begin any = 1'b1; g = 1'b1; end
    end
    e0 = any && !g;
    e1 = any && g;
    check("m_req0_ready", req0_ready, e0);
    check("m_req1_ready", req1_ready, e1);
    check("m_rsp_valid", rsp_valid, m_valid);
    check("m_rsp_id", rsp_id, m_id);
    check("m_rsp_data", rsp_data, m_data);
    check("m_rsp_zero", rsp_zero, m_zero);
    if (p0_stall && req0_valid)
      check("hold_req0", {req0_ctrl, req0_a[15:0], req0_b[12:0]} ^ {p0_c, p0_a[15:0], p0_b[12:0]}, 0);
    if (p1_stall && req1_valid)
      check("hold_req1", {req1_ctrl, req1_a[15:0], req1_b[12:0]} ^ {p1_c, p1_a[15:0], p1_b[12:0]}, 0);
    p0_stall = req0_valid && !req0_ready; p0_c = req0_ctrl; p0_a = req0_a; p0_b = req0_b;
    p1_stall = req1_valid && !req1_ready; p1_c = req1_ctrl; p1_a = req1_a; p1_b = req1_b;
    if (rst) begin
      m_valid = 0; m_id = 0; m_data = 0; m_zero = 0; m_last = 1;
    end else if (any) begin
      m_valid = 1; m_id = g; m_last = g;
      m_data = g ? ref_alu(req1_ctrl, req1_a, req1_b) : ref_alu(req0_ctrl, req0_a, req0_b);
      m_zero = (m_data == 0);
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic samp();
    @(negedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 0;
      1: return 1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit hs0, hs1, g;
    // Reset held with a pending request: nobody may be granted.
    req0_valid = 1; req0_ctrl = 3'd0; req0_a = 5; req0_b = 7;
    samp(); check("rst_valid", rsp_valid, 0); check("rst_r0", req0_ready, 0); check("rst_r1", req1_ready, 0);
    step(); samp(); check("rst2_valid", rsp_valid, 0); check("rst2_r0", req0_ready, 0);
    step(); rst = 0; req0_valid = 0;
    samp(); check("idle_valid", rsp_valid, 0);
    step(); samp(); check("idle2_valid", rsp_valid, 0);

    step(); req0_valid = 1; rsp_ready = 1;
    samp(); check("add_ready", req0_ready, 1);
    step(); req0_valid = 0;
    samp(); check("add_valid", rsp_valid, 1); check("add_data", rsp_data, 12);
    check("add_id", rsp_id, 0); check("add_zero", rsp_zero, 0);

    // Conflict sequence starts from a freshly reset pointer.
    step(); rst = 1;
    samp();
    step(); rst = 0;
    req0_valid = 1; req0_ctrl = 3'd1; req0_a = 3; req0_b = 3;
    req1_valid = 1; req1_ctrl = 3'd3; req1_a = 32'hF0; req1_b = 32'h0F;
    for (int i = 0; i < 5; i++) begin
      samp();
      if (i < 4) begin
        g = FIXED ? 1'b0 : i[0];
        check("rr_r0", req0_ready, !g);
        check("rr_r1", req1_ready, g);
      end
      if (i > 0) begin
        g = FIXED ? 1'b0 : !i[0];
        check("rr_data", rsp_data, g ? 32'hFF : 32'h0);
        check("rr_zero", rsp_zero, !g);
        check("rr_id", rsp_id, g);
      end
      step();
      if (i == 3) begin req0_valid = 0; req1_valid = 0; end
    end

    req1_valid = 1; req1_ctrl = 3'd5; req1_a = 32'hFFFF_FFFF; req1_b = 1;
    samp(); check("slt_ready", req1_ready, 1);
    step(); req1_a = 1; req1_b = 32'hFFFF_FFFF;
    samp(); check("slt1_data", rsp_data, 1); check("slt1_id", rsp_id, 1);
    step(); req1_ctrl = 3'd7;
    samp(); check("slt0_data", rsp_data, 0); check("slt0_zero", rsp_zero, 1);
    step(); req1_valid = 0;
    samp(); check("bad_data", rsp_data, 0); check("bad_zero", rsp_zero, 1);

    step(); req0_valid = 1; req0_ctrl = 3'd0; req0_a = 1; req0_b = 1;
    samp(); check("st_acc", req0_ready, 1);
    step(); req0_ctrl = 3'd2; req0_a = 32'hC; req0_b = 32'hA; rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      samp(); check("st_valid", rsp_valid, 1); check("st_data", rsp_data, 2); check("st_r0", req0_ready, 0);
      if (k < 2) step();
    end
    step(); rsp_ready = 1;
    samp(); check("dr_r0", req0_ready, 1); check("dr_data", rsp_data, 2);
    step(); req0_valid = 0;
    samp(); check("dr_valid", rsp_valid, 1); check("dr_new", rsp_data, 8);

    step(); rsp_ready = 0; rst = 1;
    req0_valid = 1; req0_ctrl = 3'd0; req0_a = 2; req0_b = 2;
    req1_valid = 1; req1_ctrl = 3'd0; req1_a = 3; req1_b = 3;
    samp(); check("mr_r0", req0_ready, 0); check("mr_r1", req1_ready, 0);
    step(); rst = 0; rsp_ready = 1;
    samp(); check("mr_valid", rsp_valid, 0); check("mr_win0", req0_ready, 1); check("mr_lose1", req1_ready, 0);
    step();
    samp(); check("mr_next1", req1_ready, !FIXED); check("mr_d0", rsp_data, 4); check("mr_id0", rsp_id, 0);
    step(); req1_valid = 0;
    samp(); check("mr_d1", rsp_data, FIXED ? 4 : 6); check("mr_id1", rsp_id, !FIXED);
    step(); req0_valid = 0;
    samp();

    // Randomized traffic; requests change only after their handshake.
    hs0 = 0; hs1 = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid || hs0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_ctrl = 3'($urandom_range(0, 7)); req0_a = rnd_val(); req0_b = rnd_val();
      end
      if (!req1_valid || hs1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_ctrl = 3'($urandom_range(0, 7)); req1_a = rnd_val(); req1_b = rnd_val();
      end
      samp();
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
    end
    step(); rst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (3) samp();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
